// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 receiver that turns raw keyboard frames into the 11-bit ps2_key event word.
// Optional ps2_clk glitch filter is built in when PS2_FILTER_EN is defined.
module ps2_key_encoder #(
    parameter int TIMEOUT_CYC = 24000,
    parameter int FILTER_LEN  = 8
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        rx_err,
    output logic        busy
);

`ifdef PS2_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic         clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, lvl_prev_q;
    logic         clk_lvl;
    logic         fall;
    state_t       state_q;
    logic [2:0]   bit_cnt_q;
    logic [7:0]   shift_q;
    logic         par_q;
    logic         ext_q, brk_q;
    logic [TW-1:0] to_cnt_q;
    logic         is_noise;
    logic         timeout;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            lvl_prev_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            lvl_prev_q <= clk_lvl;
        end
    end

    generate
        if (FILT_EN && FILTER_LEN > 0) begin : g_filter
            localparam int FW = $clog2(FILTER_LEN + 1);
            logic          filt_q;
            logic [FW-1:0] fcnt_q;

            // Level flips only after FILTER_LEN consecutive samples disagree with it.
            always_ff @(posedge clk_sys) begin
                if (RESET) begin
                    filt_q <= 1'b1;
                    fcnt_q <= '0;
                end else if (clk_s2_q == filt_q) begin
                    fcnt_q <= '0;
                end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_q <= clk_s2_q;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end
            assign clk_lvl = filt_q;
        end else begin : g_nofilter
            assign clk_lvl = clk_s2_q;
        end
    endgenerate

    assign fall    = lvl_prev_q & ~clk_lvl;
    assign timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign busy    = (state_q != IDLE);

    always_comb begin
        is_noise = 1'b0;
        case (shift_q)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_noise = 1'b1;
            default:                                  is_noise = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            to_cnt_q   <= '0;
            ps2_key    <= '0;
            key_strobe <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            rx_err     <= 1'b0;
            // Timeout takes priority over a coincident clock edge.
            if (timeout) begin
                rx_err   <= 1'b1;
                state_q  <= IDLE;
                ext_q    <= 1'b0;
                brk_q    <= 1'b0;
                to_cnt_q <= '0;
            end else begin
                if (state_q == IDLE || fall)
                    to_cnt_q <= '0;
                else
                    to_cnt_q <= to_cnt_q + 1'b1;

                if (fall) begin
                    case (state_q)
                        IDLE: begin
                            if (!dat_s2_q) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end
                        DATA: begin
                            shift_q   <= {dat_s2_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7)
                                state_q <= PARITY;
                        end
                        PARITY: begin
                            par_q   <= dat_s2_q;
                            state_q <= STOP;
                        end
                        STOP: begin
                            state_q <= IDLE;
                            if (dat_s2_q && (^{shift_q, par_q})) begin
                                if (shift_q == 8'hE0) begin
                                    ext_q <= 1'b1;
                                end else if (shift_q == 8'hF0) begin
                                    brk_q <= 1'b1;
                                end else if (!(is_noise && !ext_q && !brk_q)) begin
                                    ps2_key    <= {~ps2_key[10], ~brk_q, ext_q, shift_q};
                                    key_strobe <= 1'b1;
                                    ext_q      <= 1'b0;
                                    brk_q      <= 1'b0;
                                end
                            end else begin
                                rx_err <= 1'b1;
                                ext_q  <= 1'b0;
                                brk_q  <= 1'b0;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: table of frames plus hand-written corner sequences,
// with a scoreboard queue of expected ps2_key words popped on each key_strobe.
module tb_ps2_key_encoder;

    localparam int TO   = 24000;
    localparam int FL   = 8;
    localparam int HALF = 20;
`ifdef PS2_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        key_strobe, rx_err, busy;

    ps2_key_encoder #(.TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .rx_err     (rx_err),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         ev;
        logic [9:0] low;
        bit         err;
    } vec_t;

    vec_t        vecs[17];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          strobe_seen = 0;
    logic        strobe_prev = 1'b0;
    int          stop_cyc = 0;
    int          lat_meas = -1;
    logic        model_t = 1'b0;
    logic [10:0] last_key = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Output monitor, run once per cycle on the falling clock edge.
    task automatic sample();
        logic [10:0] e;
        if (rx_err === 1'b1) err_seen++;
        if (key_strobe === 1'b1) begin
            strobe_seen++;
            check("strobe_width", {31'd0, strobe_prev}, 32'd0);
            if (lat_meas < 0) lat_meas = cyc - stop_cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: ps2_key=%h, required no event", ps2_key);
            end else begin
                e = exp_q.pop_front();
                check("key_value", {21'd0, ps2_key}, {21'd0, e});
            end
        end
        strobe_prev = key_strobe;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            sample();
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic expect_event(input logic [9:0] low);
        model_t  = ~model_t;
        last_key = {model_t, low};
        exp_q.push_back(last_key);
    endtask

    task automatic check_settled(input string tag, input int e0, input int exp_err, input int s0, input int exp_str);
        tick(HALF);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_rx_err"}, err_seen - e0, exp_err);
        check({tag, "_strobes"}, strobe_seen - s0, exp_str);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_key"}, {21'd0, ps2_key}, {21'd0, last_key});
        exp_q.delete();
    endtask

    initial begin
        int e0, s0;
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h21C, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[4]  = '{8'h75, 1'b0, 1'b1, 10'h375, 1'b0};
        vecs[5]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[7]  = '{8'h75, 1'b0, 1'b1, 10'h175, 1'b0};
        vecs[8]  = '{8'h29, 1'b1, 1'b0, 10'h000, 1'b1};
        vecs[9]  = '{8'h29, 1'b0, 1'b1, 10'h229, 1'b0};
        vecs[10] = '{8'hAA, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[11] = '{8'hFA, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[13] = '{8'hAA, 1'b0, 1'b1, 10'h0AA, 1'b0};
        vecs[14] = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[15] = '{8'h75, 1'b1, 1'b0, 10'h000, 1'b1};
        vecs[16] = '{8'h75, 1'b0, 1'b1, 10'h275, 1'b0};

        tick(3);
        check("reset_key", {21'd0, ps2_key}, 32'd0);
        check("reset_strobe", {31'd0, key_strobe}, 32'd0);
        check("reset_err", {31'd0, rx_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        RESET = 1'b0;
        tick(5);

        for (int v = 0; v < 17; v++) begin
            e0 = err_seen;
            s0 = strobe_seen;
            if (vecs[v].ev) expect_event(vecs[v].low);
            send_bits(frame_of(vecs[v].data, vecs[v].bad_par), 0, 10);
            check_settled($sformatf("vec%0d", v), e0, vecs[v].err, s0, vecs[v].ev);
            if (v == 0) check("latency", lat_meas, LAT);
        end

        // Partial frame abandoned by timeout, then a clean frame.
        e0 = err_seen;
        s0 = strobe_seen;
        send_bits(frame_of(8'h16, 1'b0), 0, 4);
        tick(TO - 200);
        check("timeout_busy_before", {31'd0, busy}, 32'd1);
        check("timeout_no_err_yet", err_seen - e0, 0);
        tick(400);
        check_settled("timeout", e0, 1, s0, 0);
        e0 = err_seen;
        s0 = strobe_seen;
        expect_event(10'h216);
        send_bits(frame_of(8'h16, 1'b0), 0, 10);
        check_settled("after_timeout", e0, 0, s0, 1);

        // E0 prefix and a partial frame both wiped by reset.
        send_bits(frame_of(8'hE0, 1'b0), 0, 10);
        send_bits(frame_of(8'h1C, 1'b0), 0, 5);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("midreset_key", {21'd0, ps2_key}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        ps2_data = 1'b1;
        model_t  = 1'b0;
        last_key = '0;
        exp_q.delete();
        tick(HALF);
        e0 = err_seen;
        s0 = strobe_seen;
        expect_event(10'h275);
        send_bits(frame_of(8'h75, 1'b0), 0, 10);
        check_settled("after_reset", e0, 0, s0, 1);
        check("after_reset_word", {21'd0, ps2_key}, 32'h675);

        // 3-cycle low glitch on ps2_clk while data is low.
        e0 = err_seen;
        s0 = strobe_seen;
        ps2_data = 1'b0;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(HALF);
`ifdef PS2_FILTER_EN
        check("glitch_busy", {31'd0, busy}, 32'd0);
        ps2_data = 1'b1;
        check_settled("glitch", e0, 0, s0, 0);
`else
        check("glitch_busy", {31'd0, busy}, 32'd1);
        expect_event(10'h21C);
        send_bits(frame_of(8'h1C, 1'b0), 1, 10);
        check_settled("glitch", e0, 0, s0, 1);
`endif

        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
